// File: rtl/ram_seq_checker_pkg.sv
// ram_seq_checker_pkg
// Constants and types shared by the RAM sequence generator and checker:
// RAM geometry and the sequencer state encoding.
package ram_seq_checker_pkg;

  localparam int SEQ_ADDR_W = 6;
  localparam int SEQ_DATA_W = 32;
  localparam int SEQ_DEPTH  = 1 << SEQ_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_CAP  = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/ram_seq_checker.sv
// ram_seq_checker
// Reads NWORDS words from RAM port B starting at address 0, streams each
// word out on a valid/ready interface, and checks that every word from
// index 2 onward equals the (wrapping) sum of the two words before it.
//
// state | meaning
// IDLE  | waiting for start after reset
// READ  | ram_en asserted for address index
// CAP   | RAM data captured, sequence check applied
// OUT   | word presented, waiting for handshake
// DONE  | run complete, waiting for a new start
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle run request (ignored while busy)
//   ram_en/ram_addr       RAM port B read request
//   ram_dout              RAM read data, valid the cycle after ram_en
//   out_valid/out_ready   output handshake
//   out_data/out_addr     word and its address
//   busy, done            run status (done is sticky)
//   err, err_addr         sticky mismatch flag and first mismatch address
module ram_seq_checker
  import ram_seq_checker_pkg::*;
#(
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int DATA_W = SEQ_DATA_W,
  parameter int NWORDS = SEQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NWORDS - 1);

  seq_state_t        state;
  logic [ADDR_W-1:0] index;
  logic [DATA_W-1:0] prev1;
  logic [DATA_W-1:0] prev2;
  logic [DATA_W-1:0] expected;
  logic              mismatch;

  // Carry out of the sum is intentionally dropped.
  assign expected = prev1 + prev2;
  assign mismatch = (index >= ADDR_W'(2)) && (ram_dout != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      index     <= '0;
      prev1     <= '0;
      prev2     <= '0;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_addr  <= '0;
    end else begin
      ram_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_READ;
            index    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
            busy     <= 1'b1;
            ram_en   <= 1'b1;
            ram_addr <= '0;
          end
        end
        ST_READ: begin
          state <= ST_CAP;
        end
        ST_CAP: begin
          out_data  <= ram_dout;
          out_addr  <= index;
          prev1     <= ram_dout;
          prev2     <= prev1;
          out_valid <= 1'b1;
          state     <= ST_OUT;
          // Only the first mismatch is recorded.
          if (mismatch && !err) begin
            err      <= 1'b1;
            err_addr <= index;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (index == LAST_IDX) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= ST_READ;
              index    <= index + 1'b1;
              ram_en   <= 1'b1;
              ram_addr <= index + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_seq_checker.sv
// tb_ram_seq_checker
// Self-checking bench: behavioural RAM, a stream model (expected address
// counter + first-error index computed from RAM contents) checked every
// cycle a word is valid, and directed/randomized runs.
module tb_ram_seq_checker;
  import ram_seq_checker_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_addr;

  ram_seq_checker #(.ADDR_W(AW), .DATA_W(DW), .NWORDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  int            n_checks = 0;
  int            n_errs   = 0;
  int            next_addr = 0;
  int            first_err = N;
  int            ready_mode = 0;
  logic [DW-1:0] w47 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int calc_first_err();
    logic [DW-1:0] s;
    for (int i = 2; i < N; i++) begin
      s = mem[i-1] + mem[i-2];
      if (mem[i] != s) return i;
    end
    return N;
  endfunction

  task automatic fill_seq(input logic [DW-1:0] a, input logic [DW-1:0] b);
    mem[0] = a;
    mem[1] = b;
    for (int i = 2; i < N; i++) mem[i] = mem[i-1] + mem[i-2];
  endtask

  // Stream model: tracks which address must be on the output next.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) next_addr = 0;
    else if (start && !busy) begin
      next_addr = 0;
      first_err = calc_first_err();
    end else if (out_valid && out_ready) next_addr++;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("out_addr", 64'(out_addr), 64'(next_addr));
      if (next_addr < N) check("out_data", 64'(out_data), 64'(mem[next_addr]));
      check("ram_en_while_valid", 64'(ram_en), 64'd0);
      check("busy_while_valid", 64'(busy), 64'd1);
      check("err", 64'(err), 64'(first_err <= next_addr));
      check("err_addr", 64'(err_addr), (first_err <= next_addr) ? 64'(first_err) : 64'd0);
      if (next_addr == 47) w47 = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic wait_done(input int poke, output int cyc);
    cyc = 0;
    while (!done && cyc < 5000) begin
      if (cyc == poke) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
    end
    check("done_timeout", 64'(done), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    check("word_count", 64'(next_addr), 64'(N));
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears", 64'({busy, done, err, err_addr}), 64'({1'b1, 1'b0, 1'b0, 6'd0}));
  endtask

  task automatic run(input int poke, output int cyc);
    kick();
    wait_done(poke, cyc);
    check("final_err", 64'(err), 64'(first_err < N));
    check("final_err_addr", 64'(err_addr), (first_err < N) ? 64'(first_err) : 64'd0);
  endtask

  initial begin
    int cyc;
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    fill_seq(32'd1, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({ram_en, ram_addr, out_valid, out_data, out_addr, busy, done, err, err_addr}), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_no_start", 64'({busy, done, ram_en}), 64'd0);

    // Clean Fibonacci run with full-rate consumer, including wrap past fib(47).
    ready_mode = 0;
    run(-1, cyc);
    check("run_cycles", 64'(cyc), 64'd192);
    check("err_clean", 64'(err), 64'd0);
    check("wrap_word47", 64'(w47), 64'h1E8D0A40);

    // Corrupt address 10: first error recorded at 10, later ones ignored.
    mem[10] = '0;
    run(-1, cyc);
    check("err_set", 64'(err), 64'd1);
    check("err_addr_10", 64'(err_addr), 64'd10);
    check("done_with_err", 64'(done), 64'd1);

    // Backpressure while address 3 is presented.
    fill_seq(32'd1, 32'd1);
    kick();
    k = 0;
    while (!(out_valid && out_addr == 6'd3) && k < 100) begin tick(); k++; end
    check("reach_addr3", 64'(out_addr), 64'd3);
    ready_mode = 2;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'd3);
      check("bp_ram_en", 64'(ram_en), 64'd0);
    end
    ready_mode = 0;
    out_ready = 1'b1;
    k = 0;
    while (!ram_en && k < 10) begin tick(); k++; end
    check("read_after_hs", 64'({ram_en, ram_addr}), 64'({1'b1, 6'd4}));
    wait_done(-1, cyc);

    // Start pulsed mid-run is ignored; random backpressure.
    ready_mode = 1;
    run(30, cyc);

    // Reset mid-run at address 20, then restart from address 0.
    ready_mode = 0;
    kick();
    k = 0;
    while (!(out_valid && out_addr == 6'd20) && k < 200) begin tick(); k++; end
    check("reach_addr20", 64'(out_addr), 64'd20);
    rst_n = 1'b0;
    #1;
    check("reset_midrun", 64'({ram_en, ram_addr, out_valid, out_data, out_addr, busy, done, err, err_addr}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run(-1, cyc);
    check("restart_cycles", 64'(cyc), 64'd192);

    // Randomized contents, optional corruption, random backpressure.
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      fill_seq($urandom, $urandom);
      if ($urandom_range(0, 1) == 1) mem[$urandom_range(2, N-1)] = $urandom;
      run(int'($urandom_range(5, 60)), cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
